vcpu32_fetch_stage: RTL and testbench
=====================================

// Module: vcpu32_fetch_stage
// PURPOSE
//  Instruction fetch stage directly upstream of the vcpu32 pipeline core; produces {pc, instr} pairs it consumes.
//  Owns the fetch PC and issues word-aligned requests to instruction memory, with up to DEPTH requests in flight.
//  Buffers in-order responses in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
//  Redirects (branch/trap) from the core flush the FIFO and discard stale in-flight responses.
// PARAMETERS
//  DEPTH     4             FIFO entries and max outstanding requests; power of two, >= 2
//  RESET_PC  32'h0000_0000 fetch PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   asynchronous reset, active-low (0 = reset)
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  byte address of request, bits [1:0] always 0
//  imem_rsp_valid  in   1   response valid; responses return in request order, always accepted
//  imem_rsp_data   in   32  instruction word
//  imem_rsp_err    in   1   access fault for this response
//  redirect_valid  in   1   core redirects fetch this cycle
//  redirect_pc     in   32  new fetch PC; bits [1:0] ignored, treated as 0
//  out_valid       out  1   fetch packet valid toward decode
//  out_ready       in   1   decode accepts packet
//  out_pc          out  32  address of out_instr
//  out_instr       out  32  instruction word
//  out_err         out  1   packet carries an access fault, out_instr is don't-care
//  fetch_halted    out  1   state == HALT
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, FIFO empty, inflight=0, discard=0, state=RUN; all outputs 0 except imem_req_addr=RESET_PC.
//  Issue: imem_req_valid = (state==RUN) & !redirect_valid & (fifo_count + inflight < DEPTH); imem_req_addr = pc.
//   On req_valid & req_ready: inflight++, pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0). Stored pc of each request is tagged in a
//   DEPTH-entry address queue so responses pair with their address.
//  Response: inflight-- on every rsp_valid. If discard > 0: drop response, discard--. Else push {addr, data, err} to FIFO.
//   Credit rule guarantees no push into a full FIFO; bench asserts this never occurs.
//  Output: out_* driven from FIFO head; out_valid = !fifo_empty & !redirect_valid. Pop on out_valid & out_ready.
//   Push and pop in one cycle: count unchanged. Latency: response in cycle N visible on out_* in N+1 (registered FIFO).
//  FSM: RUN -> HALT when a response with err=1 is pushed (issue stops next cycle; already-issued requests still complete and
//   are buffered). HALT -> RUN only on redirect_valid. Err packet still delivered to decode with out_err=1.
//  Redirect (redirect_valid=1, cycle N): FIFO flushed; pc <= {redirect_pc[31:2],2'b00}; state <= RUN;
//   discard <= inflight after this cycle's response is counted (response arriving in cycle N is also dropped);
//   no request issued and no packet transferred in cycle N. First new request issues in N+1.
//  Redirect while discard > 0: discard reloads to current inflight, not accumulated.
//  Counters inflight, discard, fifo_count are log2(DEPTH)+1 bits; never exceed DEPTH.
//  Reset mid-operation: all state cleared immediately; any response arriving after reset release with inflight=0 is ignored.
// TESTING
//  1 Reset, RESET_PC=0, memory 1-cycle latency, out_ready=1 -> packets pc=0,4,8,12... back-to-back, one per cycle after fill.
//  2 out_ready=0 for 20 cycles -> exactly DEPTH=4 requests issued, FIFO holds pc 0..12, req_valid low; release -> in-order drain.
//  3 Memory latency 3, redirect_pc=32'h0000_1002 with 3 in flight -> 3 stale responses dropped, next packet pc=32'h1000.
//  4 Response err=1 for pc=8 -> out_err=1 on pc=8, fetch_halted=1, no further requests; redirect to 0x40 -> resumes at 0x40.
//  5 Redirect to 32'hFFFF_FFF8 -> packets 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
//  6 Assert rst low mid-stream with 2 in flight and FIFO=3 -> outputs 0, pc=RESET_PC; fetch restarts cleanly after release.

Source files
------------

// File: rtl/vcpu32_fetch_stage.sv
// Instruction fetch stage for vcpu32: owns the fetch PC, keeps up to DEPTH memory requests
// in flight, buffers in-order responses in a FIFO and hands {pc, instr} packets to decode.
module vcpu32_fetch_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        fetch_halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, HALT} state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [31:0]     r_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_aqWr;
    logic [AW-1:0]   r_aqRd;
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [31:0]     r_aqAddr    [DEPTH];
    logic [31:0]     r_fifoPc    [DEPTH];
    logic [31:0]     r_fifoInstr [DEPTH];
    logic [DEPTH-1:0] r_fifoErr;

    logic [CW:0]     w_used;
    logic            w_issue;
    logic            w_rspTaken;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_inflightNext;
    logic            w_unusedLsbs;

    // Buffered packets plus outstanding requests must fit in the FIFO, so a push can never overflow.
    assign w_used         = {1'b0, r_count} + {1'b0, r_inflight};
    assign imem_req_valid = rst & (r_state == RUN) & ~redirect_valid & (w_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_issue        = imem_req_valid & imem_req_ready;
    assign w_rspTaken     = imem_rsp_valid & (r_inflight != '0);
    assign w_push         = w_rspTaken & (r_discard == '0) & ~redirect_valid;
    assign out_valid      = (r_count != '0) & ~redirect_valid;
    assign w_pop          = out_valid & out_ready;
    assign w_inflightNext = r_inflight + CW'(w_issue) - CW'(w_rspTaken);
    assign w_unusedLsbs   = ^redirect_pc[1:0];

    assign out_pc       = r_fifoPc[r_rdPtr];
    assign out_instr    = r_fifoInstr[r_rdPtr];
    assign out_err      = r_fifoErr[r_rdPtr];
    assign fetch_halted = (r_state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (redirect_valid) begin
            w_stateNext = RUN;
        end else if (w_push && imem_rsp_err) begin
            w_stateNext = HALT;
        end
    end

    // Every response pops the address tag queue, including responses that are being discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_aqWr     <= '0;
            r_aqRd     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_aqAddr[i] <= '0;
            end
        end else begin
            if (redirect_valid) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_issue) begin
                r_aqAddr[r_aqWr] <= r_pc;
                r_aqWr           <= r_aqWr + 1'b1;
            end
            if (w_rspTaken) begin
                r_aqRd <= r_aqRd + 1'b1;
            end
            r_inflight <= w_inflightNext;
            if (redirect_valid) begin
                r_discard <= w_inflightNext;
            end else if (w_rspTaken && (r_discard != '0)) begin
                r_discard <= r_discard - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_fifoErr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifoPc[i]    <= '0;
                r_fifoInstr[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifoPc[r_wrPtr]    <= r_aqAddr[r_aqRd];
                r_fifoInstr[r_wrPtr] <= imem_rsp_data;
                r_fifoErr[r_wrPtr]   <= imem_rsp_err;
                r_wrPtr              <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_vcpu32_fetch_stage.sv
// Testbench for vcpu32_fetch_stage: randomized memory/decode timing against a packet-stream
// reference model (expected fetch order, memory contents, fault map, credit limit).
module tb_vcpu32_fetch_stage;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_err;
    logic        fetch_halted;

    vcpu32_fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_err        (out_err),
        .fetch_halted   (fetch_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } req_t;

    req_t        memQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          epoch = 0;
    int          pendingPkts = 0;
    int          memLat = 1;
    int          reqPct = 100;
    int          outPct = 100;
    int          sinceMark = 0;
    logic [31:0] expIssuePc = RESET_PC;
    logic [31:0] expOutPc = RESET_PC;
    logic [31:0] firstPc = 32'h0;
    logic [31:0] errAddr = 32'h8;
    bit          errEn = 1'b0;
    bit          modelHalted = 1'b0;
    bit          awaitFirst = 1'b1;
    bit          errDelivered = 1'b0;
    bit          spurious = 1'b0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit isErr(input logic [31:0] a);
        return errEn && (a == errAddr);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered at a negedge, drives inputs, checks at +1, returns at the next negedge.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc);
        bit          rspReal;
        bit          expReq;
        req_t        r;
        logic [31:0] target;
        rspReal        = 1'b0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(0, 99) < reqPct);
        out_ready      = ($urandom_range(0, 99) < outPct);
        if (memQ.size() > 0 && memQ[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memQ[0].addr);
            imem_rsp_err   = isErr(memQ[0].addr);
            rspReal        = 1'b1;
        end else if (spurious) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            imem_rsp_err   = 1'b0;
        end
        spurious = 1'b0;
        #1;
        checkOutput("fetch_halted", fetch_halted, modelHalted);
        expReq = !modelHalted && !redir && (pendingPkts + memQ.size() < DEPTH);
        checkOutput("req_valid", imem_req_valid, expReq);
        checkOutput("out_valid", out_valid, pendingPkts > 0 && !redir);
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            checkOutput("req_addr", imem_req_addr, expIssuePc);
            memQ.push_back('{addr: expIssuePc, due: cycle + memLat, ep: epoch});
            expIssuePc += 32'd4;
        end
        if (out_valid === 1'b1 && out_ready) begin
            checkOutput("out_pc", out_pc, expOutPc);
            checkOutput("out_err", out_err, isErr(expOutPc));
            if (isErr(expOutPc)) errDelivered = 1'b1;
            else checkOutput("out_instr", out_instr, memWord(expOutPc));
            if (awaitFirst) begin
                firstPc    = expOutPc;
                awaitFirst = 1'b0;
            end
            sinceMark++;
            pendingPkts--;
            expOutPc += 32'd4;
        end
        if (rspReal) begin
            r = memQ.pop_front();
            if (r.ep == epoch && !redir) begin
                pendingPkts++;
                if (isErr(r.addr)) modelHalted = 1'b1;
            end
        end
        if (redir) begin
            target      = {rpc[31:2], 2'b00};
            epoch++;
            expIssuePc  = target;
            expOutPc    = target;
            pendingPkts = 0;
            modelHalted = 1'b0;
            awaitFirst  = 1'b1;
            sinceMark   = 0;
        end
        cycle++;
        @(negedge clk);
    endtask

    // Holds reset for two cycles from a negedge and releases it at a later negedge.
    task automatic doReset();
        @(negedge clk);
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        #1;
        checkOutput("rst_req_valid", imem_req_valid, 1'b0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_err", out_err, 1'b0);
        checkOutput("rst_halted", fetch_halted, 1'b0);
        @(negedge clk);
        @(negedge clk);
        memQ.delete();
        epoch++;
        expIssuePc  = RESET_PC;
        expOutPc    = RESET_PC;
        pendingPkts = 0;
        modelHalted = 1'b0;
        awaitFirst  = 1'b1;
        sinceMark   = 0;
        rst         = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        doReset();

        // Back-to-back stream with single-cycle memory
        memLat = 1; reqPct = 100; outPct = 100;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t1_packets", sinceMark, 18);

        // Decode stalled: credits run out, then the buffered packets drain in order
        outPct = 0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t2_req_stopped", imem_req_valid, 1'b0);
        checkOutput("t2_head_valid", out_valid, 1'b1);
        checkOutput("t2_head_pc", out_pc, expOutPc);
        outPct = 100;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0);

        // Random timing with occasional redirects
        reqPct = 70; outPct = 60;
        for (int i = 0; i < 200; i++) begin
            if (i % 25 == 0) memLat = $urandom_range(1, 4);
            if ($urandom_range(0, 99) < 4) applyStimulus(1'b1, $urandom);
            else applyStimulus(1'b0, 32'h0);
        end

        // Redirect with three requests outstanding drops the stale responses
        memLat = 3; reqPct = 100; outPct = 100;
        for (int i = 0; i < 50 && memQ.size() != 3; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t3_three_inflight", memQ.size(), 3);
        applyStimulus(1'b1, 32'h0000_1002);
        for (int i = 0; i < 30 && awaitFirst; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t3_first_pc", firstPc, 32'h0000_1000);

        // Access fault at pc 8 halts fetch until the next redirect
        memLat = 1; errEn = 1'b1; errAddr = 32'h8; errDelivered = 1'b0;
        applyStimulus(1'b1, 32'h0);
        for (int i = 0; i < 40 && fetch_halted !== 1'b1; i++) applyStimulus(1'b0, 32'h0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t4_halted", fetch_halted, 1'b1);
        checkOutput("t4_no_req", imem_req_valid, 1'b0);
        checkOutput("t4_err_delivered", errDelivered, 1'b1);
        errEn = 1'b0;
        applyStimulus(1'b1, 32'h0000_0040);
        for (int i = 0; i < 20 && awaitFirst; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t4_resume_pc", firstPc, 32'h0000_0040);
        checkOutput("t4_running", fetch_halted, 1'b0);

        // Fetch PC wraps past the top of the address space
        applyStimulus(1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t5_first_pc", firstPc, 32'hFFFF_FFF8);
        checkOutput("t5_three_packets", sinceMark >= 3, 1'b1);

        // Reset while packets are buffered and requests are outstanding
        memLat = 3; outPct = 0;
        applyStimulus(1'b1, 32'h0000_0200);
        for (int i = 0; i < 30 && !(memQ.size() >= 1 && pendingPkts >= 2); i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t6_busy_before_reset", memQ.size() >= 1 && pendingPkts >= 2, 1'b1);
        doReset();
        spurious = 1'b1;
        outPct = 100;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("t6_restart_pc", firstPc, RESET_PC);
        checkOutput("t6_restart_packets", sinceMark >= 10, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
